// File: rtl/riscv_lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: RV32I func3
// width/sign encodings and the LSU state encoding.
package riscv_lsu_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic for the LSU: access legality, store lane
// replication with byte enables, and load byte/halfword extraction with
// sign or zero extension. Used once on the request side and once on the
// response side.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  func3_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_word_i,
  output logic        legal_o,
  output logic [31:0] st_data_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rd_word_i[{off_i, 3'b000} +: 8];
  assign ld_half = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

  // Legal encodings and natural alignment; unsigned widths exist only for loads
  always_comb begin
    legal_o = 1'b0;
    case (func3_i)
      F3_LB:   legal_o = 1'b1;
      F3_LH:   legal_o = ~off_i[0];
      F3_LW:   legal_o = (off_i == 2'b00);
      F3_LBU:  legal_o = ~wr_en_i;
      F3_LHU:  legal_o = ~wr_en_i & ~off_i[0];
      default: legal_o = 1'b0;
    endcase
  end

  // Replicate store data across lanes and pick the lanes to write
  always_comb begin
    st_data_o = '0;
    byte_en_o = 4'b1111;
    if (wr_en_i) begin
      case (func3_i)
        F3_SB: begin
          st_data_o = {4{wr_data_i[7:0]}};
          byte_en_o = 4'b0001 << off_i;
        end
        F3_SH: begin
          st_data_o = {2{wr_data_i[15:0]}};
          byte_en_o = off_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_data_o = wr_data_i;
          byte_en_o = 4'b1111;
        end
      endcase
    end
  end

  // Extract and extend the addressed byte/halfword of the read word
  always_comb begin
    ld_data_o = rd_word_i;
    case (func3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data_o = {24'd0, ld_byte};
      F3_LHU:  ld_data_o = {16'd0, ld_half};
      default: ld_data_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit. Checks and registers an M-stage access,
// runs one valid/ready bus transaction, formats load data and stalls the
// pipeline until the transaction is done.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_req,
  input  logic            i_lsu_wr_en,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wr_data,
  input  logic [2:0]      i_lsu_func3,
  output logic [XLEN-1:0] o_lsu_rd_data,
  output logic            o_lsu_stall,
  output logic            o_lsu_fault,
  output logic            o_bus_valid,
  output logic [XLEN-1:0] o_bus_addr,
  output logic            o_bus_wr_en,
  output logic [XLEN-1:0] o_bus_wr_data,
  output logic [3:0]      o_bus_byte_en,
  input  logic            i_bus_ready,
  input  logic            i_bus_rsp_valid,
  input  logic [XLEN-1:0] i_bus_rsp_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_e       state_q, state_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic             wr_en_q, wr_en_d;
  logic [2:0]       func3_q, func3_d;
  logic [3:0]       be_q, be_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             req_legal;
  logic [XLEN-1:0]  req_st_data;
  logic [3:0]       req_be;
  logic [XLEN-1:0]  rsp_ld_data;
  logic             timeout_hit;

  logic [XLEN-1:0]  unused_req_ld;
  logic             unused_rsp_legal;
  logic [XLEN-1:0]  unused_rsp_st;
  logic [3:0]       unused_rsp_be;

  // Request side: legality and lane alignment of the incoming access
  riscv_lsu_align u_align_req (
    .off_i     (i_lsu_addr[1:0]),
    .func3_i   (i_lsu_func3),
    .wr_en_i   (i_lsu_wr_en),
    .wr_data_i (i_lsu_wr_data),
    .rd_word_i (i_bus_rsp_data),
    .legal_o   (req_legal),
    .st_data_o (req_st_data),
    .byte_en_o (req_be),
    .ld_data_o (unused_req_ld)
  );

  // Response side: format read data using the registered offset and width
  riscv_lsu_align u_align_rsp (
    .off_i     (addr_q[1:0]),
    .func3_i   (func3_q),
    .wr_en_i   (wr_en_q),
    .wr_data_i (wdata_q),
    .rd_word_i (i_bus_rsp_data),
    .legal_o   (unused_rsp_legal),
    .st_data_o (unused_rsp_st),
    .byte_en_o (unused_rsp_be),
    .ld_data_o (rsp_ld_data)
  );

  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  assign o_bus_addr    = {addr_q[XLEN-1:2], 2'b00};
  assign o_bus_wr_en   = wr_en_q;
  assign o_bus_wr_data = wdata_q;
  assign o_bus_byte_en = be_q;
  assign o_lsu_rd_data = rd_data_q;

  // Next-state, capture and handshake outputs; all strobes forced low in reset
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    wr_en_d     = wr_en_q;
    func3_d     = func3_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    o_lsu_stall = 1'b0;
    o_lsu_fault = 1'b0;
    o_bus_valid = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (i_lsu_req) begin
          if (req_legal) begin
            o_lsu_stall = 1'b1;
            addr_d      = i_lsu_addr;
            wr_en_d     = i_lsu_wr_en;
            func3_d     = i_lsu_func3;
            wdata_d     = req_st_data;
            be_d        = req_be;
            state_d     = LSU_REQ;
          end else begin
            o_lsu_fault = 1'b1;
          end
        end
      end
      LSU_REQ: begin
        o_lsu_stall = 1'b1;
        o_bus_valid = 1'b1;
        if (i_bus_ready) begin
          if (wr_en_q) begin
            state_d = LSU_DONE;
          end else begin
            cnt_d   = '0;
            state_d = LSU_RSP;
          end
        end
      end
      LSU_RSP: begin
        o_lsu_stall = 1'b1;
        if (i_bus_rsp_valid) begin
          rd_data_d = rsp_ld_data;
          state_d   = LSU_DONE;
        end else if (timeout_hit) begin
          o_lsu_fault = 1'b1;
          rd_data_d   = '0;
          state_d     = LSU_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase

    if (i_rst) begin
      o_lsu_stall = 1'b0;
      o_lsu_fault = 1'b0;
      o_bus_valid = 1'b0;
    end
  end

  // State, request capture, load result and timeout counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= LSU_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      wr_en_q   <= 1'b0;
      func3_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      wr_en_q   <= wr_en_d;
      func3_q   <= func3_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a vector table of single accesses plus
// hand-written sequences for wait states, timeout and reset.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [31:0] addr, wd;
  logic [2:0]  f3;
  logic [31:0] rd_data;
  logic        stall, fault, bvalid, bwr;
  logic [31:0] baddr, bwdata;
  logic [3:0]  bbe;
  logic        ready, rspv;
  logic [31:0] rspd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_lsu_req       (req),
    .i_lsu_wr_en     (wr),
    .i_lsu_addr      (addr),
    .i_lsu_wr_data   (wd),
    .i_lsu_func3     (f3),
    .o_lsu_rd_data   (rd_data),
    .o_lsu_stall     (stall),
    .o_lsu_fault     (fault),
    .o_bus_valid     (bvalid),
    .o_bus_addr      (baddr),
    .o_bus_wr_en     (bwr),
    .o_bus_wr_data   (bwdata),
    .o_bus_byte_en   (bbe),
    .i_bus_ready     (ready),
    .i_bus_rsp_valid (rspv),
    .i_bus_rsp_data  (rspd)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One access with ready in the first REQ cycle and response in the first RSP cycle
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(posedge clk); #1;
    req = 1'b1; wr = v.wr; addr = v.addr; wd = v.wdata; f3 = v.f3;
    ready = 1'b1; rspv = 1'b1; rspd = v.rsp;
    @(negedge clk);
    if (v.fault) begin
      chk($sformatf("v%0d_fault", idx), 32'(fault), 32'd1);
      chk($sformatf("v%0d_fault_stall", idx), 32'(stall), 32'd0);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_no_bus", idx), 32'(bvalid), 32'd0);
      chk($sformatf("v%0d_fault_pulse", idx), 32'(fault), 32'd0);
    end else begin
      chk($sformatf("v%0d_nofault", idx), 32'(fault), 32'd0);
      chk($sformatf("v%0d_idle_stall", idx), 32'(stall), 32'd1);
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", idx), 32'(bvalid), 32'd1);
      chk($sformatf("v%0d_baddr", idx), baddr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_be", idx), 32'(bbe), 32'(v.be));
      chk($sformatf("v%0d_bwr", idx), 32'(bwr), 32'(v.wr));
      if (v.wr) chk($sformatf("v%0d_wdata", idx), bwdata, v.exp_wd);
      n = 2;
      while (stall && n < 20) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_latency", idx), 32'(n), v.wr ? 32'd3 : 32'd4);
      if (!v.wr) chk($sformatf("v%0d_rd", idx), rd_data, v.exp_rd);
    end
    @(posedge clk); #1;
    ready = 1'b0; rspv = 1'b0;
  endtask

  // Load with junk response during REQ and a number of empty RSP cycles
  task automatic load_wait(input string nm, input logic [2:0] lf3, input logic [31:0] la,
                           input logic [31:0] lrsp, input int waits, input logic [31:0] exp);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = la; f3 = lf3; ready = 1'b1;
    rspv = 1'b1; rspd = 32'h5555_5555;
    @(negedge clk);
    chk({nm, "_idle_stall"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bvalid), 32'd1);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      rspv = 1'b0;
      @(negedge clk);
      chk({nm, "_wait_stall"}, 32'(stall), 32'd1);
      chk({nm, "_wait_novalid"}, 32'(bvalid), 32'd0);
    end
    @(posedge clk); #1;
    rspv = 1'b1; rspd = lrsp;
    @(negedge clk);
    chk({nm, "_rsp_stall"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    rspv = 1'b0; ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done_stall"}, 32'(stall), 32'd0);
    chk({nm, "_rd"}, rd_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr    f3      addr          wdata          rsp            flt   be       exp_wd         exp_rd
    vecs[0]  = '{1'b1, F3_SB,  32'h0000_1003, 32'h0000_00A5, 32'h0,         1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[1]  = '{1'b1, F3_SH,  32'h0000_1002, 32'h1234_BEEF, 32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2]  = '{1'b1, F3_SH,  32'h0000_1000, 32'h0000_CAFE, 32'h0,         1'b0, 4'b0011, 32'hCAFE_CAFE, 32'h0};
    vecs[3]  = '{1'b1, F3_SW,  32'h0000_1008, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[4]  = '{1'b1, F3_SB,  32'h0000_1001, 32'h0000_0077, 32'h0,         1'b0, 4'b0010, 32'h7777_7777, 32'h0};
    vecs[5]  = '{1'b0, F3_LB,  32'h0000_2001, 32'h0,         32'h1122_8033, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80};
    vecs[6]  = '{1'b0, F3_LBU, 32'h0000_2001, 32'h0,         32'h1122_8033, 1'b0, 4'b1111, 32'h0,         32'h0000_0080};
    vecs[7]  = '{1'b0, F3_LH,  32'h0000_2002, 32'h0,         32'h8001_1234, 1'b0, 4'b1111, 32'h0,         32'hFFFF_8001};
    vecs[8]  = '{1'b0, F3_LHU, 32'h0000_2002, 32'h0,         32'h8001_1234, 1'b0, 4'b1111, 32'h0,         32'h0000_8001};
    vecs[9]  = '{1'b0, F3_LW,  32'h0000_2000, 32'h0,         32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D};
    vecs[10] = '{1'b0, F3_LH,  32'h0000_2000, 32'h0,         32'h0000_7FFF, 1'b0, 4'b1111, 32'h0,         32'h0000_7FFF};
    vecs[11] = '{1'b0, F3_LB,  32'h0000_2003, 32'h0,         32'h7F00_0000, 1'b0, 4'b1111, 32'h0,         32'h0000_007F};
    vecs[12] = '{1'b0, F3_LW,  32'h0000_3001, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[13] = '{1'b1, F3_SH,  32'h0000_3001, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[14] = '{1'b1, F3_LBU, 32'h0000_3000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 3'b011, 32'h0000_3000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[16] = '{1'b0, 3'b111, 32'h0000_3000, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[17] = '{1'b0, F3_LHU, 32'h0000_3003, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};

    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wd = '0; f3 = '0;
    ready = 1'b0; rspv = 1'b0; rspd = '0;
    repeat (2) @(posedge clk);
    #1;
    req = 1'b1; f3 = F3_LW; addr = 32'h0000_0100;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_valid", 32'(bvalid), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_be", 32'(bbe), 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Loads with three empty response cycles
    load_wait("lh_wait", F3_LH, 32'h0000_2002, 32'h8001_1234, 3, 32'hFFFF_8001);
    load_wait("lhu_wait", F3_LHU, 32'h0000_2002, 32'h8001_1234, 3, 32'h0000_8001);

    // Store held on the bus while ready is low
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; f3 = F3_SW; addr = 32'h0000_5004; wd = 32'h0BAD_F00D;
    ready = 1'b0; rspv = 1'b0;
    @(negedge clk);
    chk("sw_hold_idle_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sw_hold_valid", 32'(bvalid), 32'd1);
      chk("sw_hold_addr", baddr, 32'h0000_5004);
      chk("sw_hold_data", bwdata, 32'h0BAD_F00D);
      chk("sw_hold_be", 32'(bbe), 32'hF);
      chk("sw_hold_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(negedge clk);
    chk("sw_ready_valid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    chk("sw_done_stall", 32'(stall), 32'd0);
    chk("sw_done_valid", 32'(bvalid), 32'd0);
    @(posedge clk); #1;

    // Load with no response runs into the timeout
    req = 1'b1; wr = 1'b0; f3 = F3_LW; addr = 32'h0000_6000; ready = 1'b1; rspv = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("to_valid", 32'(bvalid), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("to_rsp%0d_fault", i), 32'(fault), (i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("to_rsp%0d_stall", i), 32'(stall), 32'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_done_stall", 32'(stall), 32'd0);
    chk("to_done_fault", 32'(fault), 32'd0);
    chk("to_rd_zero", rd_data, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_idle_valid", 32'(bvalid), 32'd0);
    chk("to_idle_stall", 32'(stall), 32'd0);

    // Reset while waiting for the response
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; f3 = F3_LW; addr = 32'h0000_7000; ready = 1'b1; rspv = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstrsp_pre_stall", 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstrsp_stall", 32'(stall), 32'd0);
    chk("rstrsp_valid", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstrsp_after_stall", 32'(stall), 32'd0);

    // Reset while the request is on the bus
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; f3 = F3_LW; addr = 32'h0000_7000; ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("rstreq_pre_valid", 32'(bvalid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstreq_valid", 32'(bvalid), 32'd0);
    chk("rstreq_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    load_wait("lbu_after_rst", F3_LBU, 32'h0000_4001, 32'h0000_F700, 0, 32'h0000_00F7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
